// File: rtl/serial_add_arbiter_if.sv
// serial_add_arbiter_if: request/grant/result bundle for serial_add_arbiter.
// The slave modport is the arbiter side; the master modport is the requester
// and result-consumer side. Define SERIAL_ADD_SUB_EN to add the per-requester
// op_sub (subtract) select.
interface serial_add_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
`ifdef SERIAL_ADD_SUB_EN
    logic [NREQ-1:0]       op_sub;
`endif
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_cout;
    logic [IDW-1:0]        res_id;

`ifdef SERIAL_ADD_SUB_EN
    modport slave (
        input  req, op_a, op_b, op_sub, res_ready,
        output gnt, busy, res_valid, res_sum, res_cout, res_id
    );
    modport master (
        output req, op_a, op_b, op_sub, res_ready,
        input  gnt, busy, res_valid, res_sum, res_cout, res_id
    );
`else
    modport slave (
        input  req, op_a, op_b, res_ready,
        output gnt, busy, res_valid, res_sum, res_cout, res_id
    );
    modport master (
        output req, op_a, op_b, res_ready,
        input  gnt, busy, res_valid, res_sum, res_cout, res_id
    );
`endif
endinterface

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: round-robin arbiter sharing one bit-serial adder among
// NREQ requesters. Each grant loads the winner's operands, adds them LSB first
// over WIDTH clocks and presents sum, carry-out and owner ID on a valid/ready
// result port. After a result is accepted one idle bubble cycle precedes the
// next arbitration.
// Optional feature macro: SERIAL_ADD_SUB_EN -- per-requester op_sub selects
// A-B (B inverted on load, carry-in 1); res_cout=1 then means no borrow.
module serial_add_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input logic                 clk,
    input logic                 rst,
    serial_add_arbiter_if.slave bus
);
    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [IDW-1:0]    ptr;        // requester with highest priority next
    logic [IDW-1:0]    win;        // combinational arbitration winner
    logic [IDW-1:0]    owner;      // requester owning the operation in flight
    int                best;       // rotated distance of current best candidate

    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic              sub_sel;

    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-2:0]  sum_sh;     // sum bits assembled so far, newest at MSB
    logic [WIDTH-1:0]  sum_full;   // sum_sh with the current sum bit on top
    logic              carry;
    logic [CNTW-1:0]   cnt;
    logic [1:0]        fa;         // {carry_out, sum_bit} of the current bit
    logic              last_bit;

    // One-bit full adder: returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Round-robin pointer advance, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] cur);
        if (cur == IDW'(NREQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = cur + IDW'(1);
        end
    endfunction

    assign fa       = full_add(a_sh[0], b_sh[0], carry);
    assign sum_full = {fa[0], sum_sh};
    assign last_bit = (cnt == CNTW'(WIDTH - 1));
    assign bus.busy = (state != IDLE);

    // Pick the asserted request closest to ptr going upward (with wrap).
    always_comb begin
        win  = '0;
        best = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req[i] && (((i + NREQ - int'(ptr)) % NREQ) < best)) begin
                best = (i + NREQ - int'(ptr)) % NREQ;
                win  = IDW'(i);
            end
        end
    end

    // Route the winner's operands (and subtract select) to the load path.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                a_sel = bus.op_a[i*WIDTH +: WIDTH];
                b_sel = bus.op_b[i*WIDTH +: WIDTH];
`ifdef SERIAL_ADD_SUB_EN
                sub_sel = bus.op_sub[i];
`endif
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: arbitrate in IDLE, run WIDTH bits, wait for acceptance.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|bus.req) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    if (bus.res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and result registers: grant pulse, pointer, counter, carry, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            owner         <= '0;
            cnt           <= '0;
            carry         <= 1'b0;
            bus.gnt       <= '0;
            bus.res_valid <= 1'b0;
            bus.res_sum   <= '0;
            bus.res_cout  <= 1'b0;
            bus.res_id    <= '0;
        end else begin
            bus.gnt <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner   <= win;
                        ptr     <= next_ptr(win);
                        cnt     <= '0;
                        carry   <= sub_sel;
                        bus.gnt <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                    end
                end
                SHIFT: begin
                    carry <= fa[1];
                    cnt   <= cnt + CNTW'(1);
                    if (last_bit) begin
                        bus.res_valid <= 1'b1;
                        bus.res_sum   <= sum_full;
                        bus.res_cout  <= fa[1];
                        bus.res_id    <= owner;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand and partial-sum shift registers; contents are don't-care until loaded.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (|bus.req) begin
                a_sh <= a_sel;
                b_sh <= sub_sel ? ~b_sel : b_sel;
            end
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_full[WIDTH-1:1];
        end
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb_serial_add_arbiter: scoreboard bench for serial_add_arbiter. Grants are
// predicted by a round-robin model, expected results are computed with plain
// arithmetic and queued; a monitor compares every cycle the result is valid.
`timescale 1ns/1ps
module tb_serial_add_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    typedef struct {
        int           id;
        logic [W-1:0] sum;
        logic         cout;
        int           gcyc;
        bit           seen;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_add_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
    serial_add_arbiter #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    exp_t         sb[$];
    int           vectors    = 0;
    int           miscompares = 0;
    int           cyc        = 0;
    int           acc_cyc    = -100;
    int           mptr       = 0;
    int           ready_mode = 0;
    logic [W-1:0] opa[N];
    logic [W-1:0] opb[N];
    logic         sub[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_winner(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom % 4)
            0:       return '0;
            1:       return '1;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [N-1:0] r);
        bus.req = r;
        for (int i = 0; i < N; i++) begin
            bus.op_a[i*W +: W] = opa[i];
            bus.op_b[i*W +: W] = opb[i];
`ifdef SERIAL_ADD_SUB_EN
            bus.op_sub[i] = sub[i];
`endif
        end
    endtask

    // Wait for a grant, check it against the model and queue the expected result.
    task automatic wait_grant(output int w);
        int   exp_w;
        exp_t e;
        w = -1;
        exp_w = model_winner(bus.req, mptr);
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (bus.gnt != '0) break;
        end
        if (bus.gnt == '0) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_timeout: got no grant, expected requester %0d", exp_w);
            return;
        end
        check("gnt_onehot", 64'(bus.gnt), 64'(1) << exp_w);
        if (acc_cyc >= 0) check("idle_bubble", 64'(cyc - acc_cyc >= 2), 64'd1);
        e.id   = exp_w;
        e.gcyc = cyc;
        e.seen = 1'b0;
        if (sub[exp_w]) begin
            e.sum  = opa[exp_w] - opb[exp_w];
            e.cout = (opa[exp_w] >= opb[exp_w]);
        end else begin
            {e.cout, e.sum} = {1'b0, opa[exp_w]} + {1'b0, opb[exp_w]};
        end
        sb.push_back(e);
        mptr = (exp_w + 1) % N;
        w = exp_w;
        @(negedge clk);
        check("gnt_pulse", 64'(bus.gnt), 64'd0);
    endtask

    task automatic drain();
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},       64'(bus.gnt),       64'd0);
        check({tag, "_busy"},      64'(bus.busy),      64'd0);
        check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_res_sum"},   64'(bus.res_sum),   64'd0);
        check({tag, "_res_cout"},  64'(bus.res_cout),  64'd0);
        check({tag, "_res_id"},    64'(bus.res_id),    64'd0);
    endtask

    // Cycle counter (counts rising edges).
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Result consumer: always ready, random, or stalled.
    initial begin
        bus.res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.res_ready = 1'b1;
                1:       bus.res_ready = 1'($urandom_range(0, 1));
                default: bus.res_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare every valid cycle against the scoreboard head.
    initial forever begin
        @(negedge clk);
        if (bus.res_valid) begin
            check("no_gnt_while_valid", 64'(bus.gnt), 64'd0);
            check("busy_while_valid", 64'(bus.busy), 64'd1);
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got id %0d sum 0x%0h, expected none", bus.res_id, bus.res_sum);
            end else begin
                if (!sb[0].seen) begin
                    check("latency", 64'(cyc - sb[0].gcyc), 64'(W));
                    sb[0].seen = 1'b1;
                end
                check("res_id",   64'(bus.res_id),   64'(sb[0].id));
                check("res_sum",  64'(bus.res_sum),  64'(sb[0].sum));
                check("res_cout", 64'(bus.res_cout), 64'(sb[0].cout));
                if (bus.res_ready) begin
                    void'(sb.pop_front());
                    acc_cyc = cyc;
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #2ms;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int rr_exp[5];
        logic [N-1:0] r;
        rr_exp = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
            sub[i] = 1'b0;
        end
        drive('0);

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Round robin with all requests held.
        for (int i = 0; i < N; i++) begin
            opa[i] = rand_op();
            opb[i] = rand_op();
        end
        drive('1);
        for (int k = 0; k < 5; k++) begin
            wait_grant(w);
            check("rr_order", 64'(w), 64'(rr_exp[k]));
            if (w >= 0) begin
                opa[w] = rand_op();
                opb[w] = rand_op();
                drive('1);
            end
        end
        drive('0);
        drain();

        // Single add with carry out of the top bit.
        opa[0] = 32'hFFFF_FFFF;
        opb[0] = 32'h0000_0001;
        drive(4'b0001);
        wait_grant(w);
        drive('0);
        drain();

        // Backpressure: result held while a new request waits.
        opa[0] = 32'h1234_5678;
        opb[0] = 32'h1111_1111;
        ready_mode = 2;
        drive(4'b0001);
        wait_grant(w);
        opa[1] = rand_op();
        opb[1] = rand_op();
        drive(4'b0010);
        for (int t = 0; t < 100 && !bus.res_valid; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("bp_sum_value", 64'(bus.res_sum), 64'h2345_6789);
        ready_mode = 0;
        wait_grant(w);
        check("bp_next_winner", 64'(w), 64'd1);
        drive('0);
        drain();

        // Reset in the middle of SHIFT discards the operation and the pointer.
        opa[0] = rand_op();
        opb[0] = rand_op();
        drive(4'b0001);
        wait_grant(w);
        drive('0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrst");
        sb.delete();
        mptr = 0;
        opa[0] = rand_op();
        opb[0] = rand_op();
        opa[2] = rand_op();
        opb[2] = rand_op();
        drive(4'b0101);
        wait_grant(w);
        check("post_reset_winner", 64'(w), 64'd0);
        drive(4'b0100);
        wait_grant(w);
        check("post_reset_second", 64'(w), 64'd2);
        drive('0);
        drain();

        // Wrap priority: after requester 3, 0 wins, then 3.
        opa[3] = rand_op();
        opb[3] = rand_op();
        drive(4'b1000);
        wait_grant(w);
        drive('0);
        drain();
        opa[0] = rand_op();
        opb[0] = rand_op();
        drive(4'b1001);
        wait_grant(w);
        check("wrap_first", 64'(w), 64'd0);
        drive(4'b1001);
        wait_grant(w);
        check("wrap_second", 64'(w), 64'd3);
        drive('0);
        drain();

`ifdef SERIAL_ADD_SUB_EN
        // Subtract: 5-7 borrows, 7-5 does not.
        sub[0] = 1'b1;
        opa[0] = 32'd5;
        opb[0] = 32'd7;
        drive(4'b0001);
        wait_grant(w);
        drive('0);
        drain();
        opa[0] = 32'd7;
        opb[0] = 32'd5;
        drive(4'b0001);
        wait_grant(w);
        drive('0);
        drain();
        sub[0] = 1'b0;
`endif

        // Randomized traffic with random result backpressure.
        ready_mode = 1;
        r = '0;
        for (int i = 0; i < N; i++) begin
            opa[i] = rand_op();
            opb[i] = rand_op();
`ifdef SERIAL_ADD_SUB_EN
            sub[i] = 1'($urandom % 2);
`endif
            r[i] = 1'($urandom % 2);
        end
        if (r == '0) r[$urandom % N] = 1'b1;
        drive(r);
        for (int k = 0; k < 40; k++) begin
            wait_grant(w);
            if (w < 0) break;
            r = bus.req;
            r[w] = 1'($urandom % 2);
            for (int i = 0; i < N; i++) begin
                if (i == w || (!r[i] && ($urandom % 3 == 0))) begin
                    if (i != w) r[i] = 1'b1;
                    opa[i] = rand_op();
                    opb[i] = rand_op();
`ifdef SERIAL_ADD_SUB_EN
                    sub[i] = 1'($urandom % 2);
`endif
                end
            end
            if (r == '0) r[$urandom % N] = 1'b1;
            drive(r);
        end
        drive('0);
        ready_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
